ahb_sram_slave: RTL and testbench

Parametrised AHB-Lite slave wrapping an on-chip byte-addressable SRAM, the first bus-attached target behind the `AHB_if` interface. It generalises the interface to configurable address/data width, memory depth and programmable wait states, and adds byte-lane writes and a two-cycle ERROR response. It sits on the slave side of the bus and presents the DUT-modport signal set.

---
 rtl/ahb_pkg.sv | 41 ++++
 rtl/ahb_sram_mem.sv | 31 +++
 rtl/ahb_sram_slave.sv | 126 ++++++++++++
 tb/tb_ahb_sram_slave.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the SRAM slave: transfer/state encodings,
// response codes, HSIZE encodings and the byte-lane strobe helper.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  // Lane mask for up to 8 byte lanes; callers slice it to DATA_W/8.
  function automatic logic [7:0] byte_strobe(input logic [2:0] size,
                                             input logic [2:0] addr_lo);
    logic [7:0] base;
    case (size)
      HSIZE_BYTE: base = 8'h01;
      HSIZE_HALF: base = 8'h03;
      HSIZE_WORD: base = 8'h0F;
      default:    base = 8'hFF;
    endcase
    return base << addr_lo;
  endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Word-organised SRAM array: one byte-strobed synchronous write port and one
// asynchronous read port sharing a single word address.
module ahb_sram_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_addr,
  input  logic [DATA_W/8-1:0]        i_strb,
  input  logic [DATA_W-1:0]          i_wdata,
  output logic [DATA_W-1:0]          o_rdata
);

  localparam int NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset; contents must survive a bus reset and a
  // reset term would also stop it mapping onto RAM macros.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (i_strb[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a byte-addressable SRAM with programmable wait
// states, byte-lane writes and a two-cycle ERROR response.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int NBYTES = DATA_W / 8;
  localparam int LANE_W = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [63:0] MEM_BYTES = 64'(DEPTH) * 64'(NBYTES);

  state_e                    r_state, w_next;
  logic [CNT_W-1:0]          r_cnt;
  logic [LANE_W+IDX_W-1:0]   r_addr;
  logic                      r_write;
  logic [2:0]                r_size;

  logic w_accept, w_load, w_err, w_oor, w_misalign, w_too_big;
  logic w_mem_we;
  logic [7:0]        w_strb_all;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused;

  // Address-phase decode; only meaningful on the edge that accepts a transfer.
  assign w_accept   = HSEL & HREADY & HTRANS[1];
  assign w_oor      = 64'(HADDR) >= MEM_BYTES;
  assign w_misalign = |(HADDR[7:0] & ((8'd1 << HSIZE) - 8'd1));
  assign w_too_big  = HSIZE > 3'(LANE_W);
  assign w_err      = w_oor | w_misalign | w_too_big;
  assign w_load     = w_accept & (r_state inside {ST_IDLE, ST_DATA, ST_ERR2});

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_next    = r_state;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (r_state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (w_load) begin
          if (w_err)                w_next = ST_ERR1;
          else if (WAIT_STATES > 0) w_next = ST_WAIT;
          else                      w_next = ST_DATA;
        end else begin
          w_next = ST_IDLE;
        end
        if (r_state == ST_ERR2) HRESP = HRESP_ERROR;
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (r_cnt == '0) w_next = ST_DATA;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        w_next    = ST_ERR2;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= HSIZE_BYTE;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_addr  <= HADDR[LANE_W+IDX_W-1:0];
        r_write <= HWRITE;
        r_size  <= HSIZE;
        r_cnt   <= CNT_LOAD;
      end else if (r_state == ST_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // The write lands on the edge that closes the DATA phase, so a read issued
  // back to back sees the new word through the asynchronous read port.
  assign w_mem_we   = (r_state == ST_DATA) & r_write;
  assign w_strb_all = byte_strobe(r_size, 3'(r_addr[LANE_W-1:0]));

  ahb_sram_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .i_clk   (HCLK),
    .i_we    (w_mem_we),
    .i_addr  (r_addr[LANE_W +: IDX_W]),
    .i_strb  (w_strb_all[NBYTES-1:0]),
    .i_wdata (HWDATA),
    .o_rdata (w_rdata)
  );

  assign HRDATA = (r_state == ST_DATA && !r_write) ? w_rdata : '0;

  assign w_unused = ^{HBURST, HPROT, HTRANS[0], w_strb_all};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one zero-wait and one three-wait instance
// on a shared bus, each selected individually.
module tb_ahb_sram_slave;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel0, hsel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata0, hrdata3;
  logic        hreadyout0, hreadyout3;
  logic        hresp0, hresp3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 hclk = ~hclk;

  ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HWDATA(hwdata), .HREADY(hreadyout0), .HRDATA(hrdata0),
    .HREADYOUT(hreadyout0), .HRESP(hresp0)
  );

  ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HWDATA(hwdata), .HREADY(hreadyout3), .HRDATA(hrdata3),
    .HREADYOUT(hreadyout3), .HRESP(hresp3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  // Single non-pipelined transfer; reports the data-phase handshake.
  task automatic xfer(input bit d3, input bit wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd,
                      output logic [31:0] rd, output int lows,
                      output logic resp_first, output logic resp_last);
    bit   done;
    logic rdy;
    done = 1'b0; lows = 0; rd = '0; resp_first = 1'b0; resp_last = 1'b0;
    hsel0 = !d3; hsel3 = d3; htrans = 2'd2; hwrite = wr; haddr = a; hsize = sz;
    cyc();
    hsel0 = 1'b0; hsel3 = 1'b0; htrans = 2'd0; hwdata = wd;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge hclk);
      rdy = d3 ? hreadyout3 : hreadyout0;
      if (i == 0) resp_first = d3 ? hresp3 : hresp0;
      if (rdy) begin
        rd        = d3 ? hrdata3 : hrdata0;
        resp_last = d3 ? hresp3 : hresp0;
        done      = 1'b1;
      end else begin
        lows++;
      end
      cyc();
    end
    check("xfer_completes", 64'(done), 64'd1);
  endtask

  logic [31:0] rd;
  int          lows;
  logic        rf, rl;

  initial begin
    hreset = 1'b1; hsel0 = 1'b0; hsel3 = 1'b0; haddr = '0; htrans = 2'd0;
    hwrite = 1'b0; hsize = 3'd2; hburst = 3'd0; hprot = 4'd0; hwdata = '0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("rst_rdy0",  64'(hreadyout0), 64'd1);
    check("rst_resp0", 64'(hresp0),     64'd0);
    check("rst_data0", 64'(hrdata0),    64'd0);
    check("rst_rdy3",  64'(hreadyout3), 64'd1);
    cyc();
    hreset = 1'b0;

    // Back-to-back write then read at 0x10, zero waits.
    hsel0 = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
    cyc();
    hwdata = 32'hDEADBEEF; hwrite = 1'b0;
    @(negedge hclk);
    check("b2b_wr_rdy", 64'(hreadyout0), 64'd1);
    cyc();
    hsel0 = 1'b0; htrans = 2'd0;
    @(negedge hclk);
    check("b2b_rd_rdy",  64'(hreadyout0), 64'd1);
    check("b2b_rd_resp", 64'(hresp0),     64'd0);
    check("b2b_rd_data", 64'(hrdata0),    64'hDEADBEEF);
    cyc();

    // Byte and halfword lane writes.
    xfer(0, 1, 32'h10, 3'd2, 32'h11223344, rd, lows, rf, rl);
    xfer(0, 1, 32'h13, 3'd0, 32'hAA000000, rd, lows, rf, rl);
    check("byte_wr_waits", 64'(lows), 64'd0);
    xfer(0, 0, 32'h10, 3'd2, 32'h0, rd, lows, rf, rl);
    check("byte_rd_data", 64'(rd), 64'hAA223344);
    xfer(0, 1, 32'h10, 3'd1, 32'h0000BEEF, rd, lows, rf, rl);
    xfer(0, 0, 32'h10, 3'd2, 32'h0, rd, lows, rf, rl);
    check("half_rd_data", 64'(rd), 64'hAA22BEEF);

    // Three wait states.
    xfer(1, 1, 32'h40, 3'd2, 32'h12345678, rd, lows, rf, rl);
    check("ws3_wr_waits", 64'(lows), 64'd3);
    xfer(1, 0, 32'h40, 3'd2, 32'h0, rd, lows, rf, rl);
    check("ws3_rd_waits", 64'(lows), 64'd3);
    check("ws3_rd_data",  64'(rd),   64'h12345678);
    check("ws3_rd_resp",  64'(rl),   64'd0);

    // Error responses leave memory untouched.
    xfer(0, 1, 32'h0, 3'd2, 32'hA5A5A5A5, rd, lows, rf, rl);
    xfer(0, 1, 32'h2, 3'd2, 32'hFFFFFFFF, rd, lows, rf, rl);
    check("misal_err1_rdy",  64'(lows), 64'd1);
    check("misal_err1_resp", 64'(rf),   64'd1);
    check("misal_err2_resp", 64'(rl),   64'd1);
    xfer(0, 0, 32'h0, 3'd2, 32'h0, rd, lows, rf, rl);
    check("misal_mem", 64'(rd), 64'hA5A5A5A5);
    xfer(0, 1, 32'h1000, 3'd2, 32'hFFFFFFFF, rd, lows, rf, rl);
    check("oor_err1_rdy",  64'(lows), 64'd1);
    check("oor_err1_resp", 64'(rf),   64'd1);
    check("oor_err2_resp", 64'(rl),   64'd1);
    xfer(0, 0, 32'h0, 3'd2, 32'h0, rd, lows, rf, rl);
    check("oor_mem", 64'(rd), 64'hA5A5A5A5);
    xfer(0, 1, 32'h8, 3'd3, 32'hFFFFFFFF, rd, lows, rf, rl);
    check("size_err2_resp", 64'(rl), 64'd1);
    xfer(1, 0, 32'h42, 3'd2, 32'h0, rd, lows, rf, rl);
    check("ws3_err_lows", 64'(lows), 64'd1);
    check("ws3_err_resp", 64'(rl),   64'd1);

    // BUSY and HSEL=0 cycles around a real NONSEQ write.
    xfer(0, 1, 32'h30, 3'd2, 32'h55555555, rd, lows, rf, rl);
    hsel0 = 1'b1; htrans = 2'd1; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd2;
    cyc();
    hwdata = 32'hBAD0BAD0; hsel0 = 1'b0; htrans = 2'd2;
    @(negedge hclk);
    check("busy_rdy",  64'(hreadyout0), 64'd1);
    check("busy_resp", 64'(hresp0),     64'd0);
    cyc();
    htrans = 2'd0;
    @(negedge hclk);
    check("nosel_rdy",  64'(hreadyout0), 64'd1);
    check("nosel_resp", 64'(hresp0),     64'd0);
    cyc();
    xfer(0, 1, 32'h34, 3'd2, 32'h77777777, rd, lows, rf, rl);
    check("ns_wr_waits", 64'(lows), 64'd0);
    xfer(0, 0, 32'h30, 3'd2, 32'h0, rd, lows, rf, rl);
    check("busy_mem", 64'(rd), 64'h55555555);
    xfer(0, 0, 32'h34, 3'd2, 32'h0, rd, lows, rf, rl);
    check("ns_mem", 64'(rd), 64'h77777777);

    // Reset in the middle of a waited write.
    xfer(1, 1, 32'h20, 3'd2, 32'h11111111, rd, lows, rf, rl);
    hsel3 = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h20; hsize = 3'd2;
    cyc();
    hsel3 = 1'b0; htrans = 2'd0; hwdata = 32'hCAFEF00D;
    cyc();
    @(negedge hclk);
    check("rst_pre_wait", 64'(hreadyout3), 64'd0);
    #1 hreset = 1'b1;
    #1;
    check("midrst_rdy",  64'(hreadyout3), 64'd1);
    check("midrst_resp", 64'(hresp3),     64'd0);
    check("midrst_data", 64'(hrdata3),    64'd0);
    cyc();
    hreset = 1'b0;
    xfer(1, 0, 32'h20, 3'd2, 32'h0, rd, lows, rf, rl);
    check("midrst_mem", 64'(rd), 64'h11111111);
    xfer(0, 0, 32'h10, 3'd2, 32'h0, rd, lows, rf, rl);
    check("rst_keeps_mem", 64'(rd), 64'hAA22BEEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
